regs_file_mp: RTL and testbench

REGS_FILE_MP -- requirements
Module: regs_file_mp

---
 rtl/regs_file_mp_pkg.sv | 7 +
 rtl/regs_file_bypass.sv | 28 ++
 rtl/regs_file_mp.sv | 96 +++++++++
 tb/tb_regs_file_mp.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/regs_file_mp_pkg.sv
// regs_file_mp_pkg: FSM state type and default sizing shared by the multi-port register file.
package regs_file_mp_pkg;
    typedef enum logic {INIT, RUN} state_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NREAD  = 2;
endpackage

// File: rtl/regs_file_bypass.sv
// regs_file_bypass: one read port; forwards same-cycle writes, zeroes register 0 and INIT reads,
// and masks the pending-producer flag when the producer is writing back right now.
module regs_file_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              busy_rd,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);
    logic hit0, hit1;
    // wen0/wen1 arrive already qualified with RUN and a nonzero address
    always_comb begin
        hit0  = wen0 && (waddr0 == raddr);
        hit1  = wen1 && (waddr1 == raddr);
        rdata = (!run || raddr == '0) ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : mem_rd;
        rbusy = run && busy_rd && !(hit0 || hit1);
    end
endmodule

// File: rtl/regs_file_mp.sv
// regs_file_mp: two-write, NREAD-read register file with write bypass, per-register busy
// scoreboard and a one-register-per-cycle clearing sweep after reset.
module regs_file_mp
    import regs_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = DEF_NREAD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [$clog2(NREGS)-1:0]  waddr0,
    input  logic [$clog2(NREGS)-1:0]  waddr1,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic [NREAD*$clog2(NREGS)-1:0] raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    input  logic                      busy_set,
    input  logic [$clog2(NREGS)-1:0]  busy_addr,
    output logic [NREAD-1:0]          rbusy,
    output logic                      ready
);
    localparam int ADDR_W = $clog2(NREGS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [NREGS];
    logic [DATA_W-1:0]   mem_d [NREGS];
    logic [NREGS-1:0]    busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                run, wen0, wen1, set_en;

    always_comb begin
        run     = state_q == RUN;
        wen0    = run && we0 && (waddr0 != '0);
        wen1    = run && we1 && (waddr1 != '0);
        set_en  = run && busy_set && (busy_addr != '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        busy_d  = busy_q;
        if (!run) begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            state_d      = (cnt_q == ADDR_W'(NREGS - 1)) ? RUN : INIT;
        end else begin
            if (wen0) begin
                mem_d[waddr0]  = wdata0;
                busy_d[waddr0] = 1'b0;
            end
            // port 1 applied last so it wins a same-address collision
            if (wen1) begin
                mem_d[waddr1]  = wdata1;
                busy_d[waddr1] = 1'b0;
            end
            if (set_en) busy_d[busy_addr] = 1'b1;
        end
        ready_d = state_d == RUN;
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        regs_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp (
            .run    (run),
            .raddr  (raddr[g*ADDR_W +: ADDR_W]),
            .wen0   (wen0),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .wen1   (wen1),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .mem_rd (mem_q[raddr[g*ADDR_W +: ADDR_W]]),
            .busy_rd(busy_q[raddr[g*ADDR_W +: ADDR_W]]),
            .rdata  (rdata[g*DATA_W +: DATA_W]),
            .rbusy  (rbusy[g])
        );
    end
endmodule

// File: tb/tb_regs_file_mp.sv
// tb_regs_file_mp: random and directed stimulus checked against an array-based reference model.
module tb_regs_file_mp;
    localparam int DW = 32, NR = 32, NRD = 2, AW = 5;

    logic clock = 1'b0, reset = 1'b1;
    logic we0 = 1'b0, we1 = 1'b0, busy_set = 1'b0;
    logic [AW-1:0] waddr0 = '0, waddr1 = '0, busy_addr = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0] rbusy;
    logic ready;

    int checks = 0, errors = 0;
    logic [DW-1:0] m_mem [NR];
    bit m_busy [NR];
    int since_rst = 0;

    always #5 clock = ~clock;

    regs_file_mp dut (
        .clock(clock), .reset(reset), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .busy_set(busy_set), .busy_addr(busy_addr),
        .rbusy(rbusy), .ready(ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(int k);
        logic [AW-1:0] a;
        a = raddr[k*AW +: AW];
        if (since_rst < NR || a == 0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_rb(int k);
        logic [AW-1:0] a;
        a = raddr[k*AW +: AW];
        return since_rst >= NR && a != 0 && m_busy[a] && !(we0 && waddr0 == a) && !(we1 && waddr1 == a);
    endfunction

    task automatic cycle();
        @(negedge clock);
        chk("ready", ready, since_rst >= NR);
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rdata%0d", k), rdata[k*DW +: DW], exp_rd(k));
            chk($sformatf("rbusy%0d", k), rbusy[k], exp_rb(k));
        end
        @(posedge clock);
        if (reset) begin
            since_rst = 0;
            m_busy = '{default: 0};
        end else if (since_rst < NR) begin
            since_rst++;
            if (since_rst == NR) m_mem = '{default: '0};
        end else begin
            if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 0; end
            if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 0; end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1;
        end
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom % 2 == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    endfunction

    task automatic rand_in();
        we0 = 1'($urandom); we1 = 1'($urandom);
        waddr0 = rand_addr(); waddr1 = rand_addr();
        wdata0 = $urandom; wdata1 = $urandom;
        busy_set = ($urandom % 3 == 0); busy_addr = rand_addr();
        for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = rand_addr();
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; busy_set = 0; raddr = '0;
        waddr0 = 0; waddr1 = 0; busy_addr = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 100) begin rand_in(); cycle(); n++; end
        chk(tag, n, 32);
    endtask

    initial begin
        @(posedge clock); #1;
        repeat (2) begin rand_in(); cycle(); end
        reset = 0;
        wait_ready("init_len");

        idle(); we0 = 1; waddr0 = 5; wdata0 = 54; raddr[0 +: AW] = 5;
        #1 chk("byp_w0", rdata[0 +: DW], 54); cycle();
        idle(); raddr[0 +: AW] = 5;
        #1 chk("stored5", rdata[0 +: DW], 54); cycle();
        idle(); we0 = 1; waddr0 = 7; wdata0 = 'h11; we1 = 1; waddr1 = 7; wdata1 = 'h22; raddr[AW +: AW] = 7;
        #1 chk("byp_prio", rdata[DW +: DW], 'h22); cycle();
        idle(); raddr[0 +: AW] = 7;
        #1 chk("stored7", rdata[0 +: DW], 'h22); cycle();
        idle(); we0 = 1; waddr0 = 0; wdata0 = '1; busy_set = 1; busy_addr = 0;
        #1 chk("r0_byp", rdata[0 +: DW], 0); cycle();
        idle();
        #1 chk("r0", rdata[0 +: DW], 0); chk("r0_busy", rbusy[0], 0); cycle();
        idle(); busy_set = 1; busy_addr = 9; raddr[0 +: AW] = 9;
        #1 chk("busy_same", rbusy[0], 0); cycle();
        idle(); raddr[0 +: AW] = 9;
        #1 chk("busy_next", rbusy[0], 1); cycle();
        idle(); we1 = 1; waddr1 = 9; wdata1 = 3; raddr[0 +: AW] = 9;
        #1 chk("busy_wclr", rbusy[0], 0); cycle();
        idle(); raddr[0 +: AW] = 9;
        #1 chk("busy_cleared", rbusy[0], 0); cycle();
        idle(); busy_set = 1; busy_addr = 9; we0 = 1; waddr0 = 9; wdata0 = 4; cycle();
        idle(); raddr[0 +: AW] = 9;
        #1 chk("busy_setwins", rbusy[0], 1); cycle();

        idle(); reset = 1; cycle();
        reset = 0;
        repeat (10) begin rand_in(); cycle(); end
        reset = 1; cycle();
        reset = 0;
        wait_ready("init_len_restart");
        idle(); raddr[0 +: AW] = 5;
        #1 chk("swept5", rdata[0 +: DW], 0); cycle();

        repeat (600) begin
            rand_in();
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
